regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, issue/writeback strobes, clear handshake.
interface regfile_scoreboard_if #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [WORD_SIZE-1:0]  rv1;
  logic [WORD_SIZE-1:0]  rv2;
  logic                  busy1;
  logic                  busy2;
  logic                  iss_en;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [WORD_SIZE-1:0]  wb_data;
  logic                  clr_req;
  logic                  ready;

  modport master (
    output rs1, rs2, iss_en, iss_rd, wb_en, wb_rd, wb_data, clr_req,
    input  rv1, rv2, busy1, busy2, ready
  );

  modport slave (
    input  rs1, rs2, iss_en, iss_rd, wb_en, wb_rd, wb_data, clr_req,
    output rv1, rv2, busy1, busy2, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-entry busy scoreboard and a sequenced one-entry-per-cycle clear.
// Optional same-cycle writeback forwarding to the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [WORD_SIZE-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic                  wb_fire;
  logic                  iss_fire;
  logic [WORD_SIZE-1:0]  rv1;
  logic [WORD_SIZE-1:0]  rv2;
  logic                  busy1;
  logic                  busy2;

  // Entry 0 is hardwired when ZERO_REG is set.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign bus.ready = (state == IDLE);
  assign wb_fire   = bus.wb_en  && (state == IDLE) && writable(bus.wb_rd);
  assign iss_fire  = bus.iss_en && (state == IDLE) && writable(bus.iss_rd);

  // State, storage and scoreboard update; issue is applied after writeback so it wins on a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_fire) begin
            mem[bus.wb_rd]  <= bus.wb_data;
            busy[bus.wb_rd] <= 1'b0;
          end
          if (iss_fire) busy[bus.iss_rd] <= 1'b1;
          if (bus.clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          mem[ptr]  <= '0;
          busy[ptr] <= 1'b0;
          if (ptr == LAST) state <= IDLE;
          else             ptr   <= ptr + ADDR_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read port A: storage lookup, optional writeback forwarding, zero-register mask.
  always_comb begin
    rv1   = mem[bus.rs1];
    busy1 = busy[bus.rs1];
`ifdef REGFILE_BYPASS_EN
    if (wb_fire && (bus.wb_rd == bus.rs1)) begin
      rv1   = bus.wb_data;
      busy1 = iss_fire && (bus.iss_rd == bus.rs1);
    end
`endif
    if ((ZERO_REG != 0) && (bus.rs1 == '0)) begin
      rv1   = '0;
      busy1 = 1'b0;
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    rv2   = mem[bus.rs2];
    busy2 = busy[bus.rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_fire && (bus.wb_rd == bus.rs2)) begin
      rv2   = bus.wb_data;
      busy2 = iss_fire && (bus.iss_rd == bus.rs2);
    end
`endif
    if ((ZERO_REG != 0) && (bus.rs2 == '0)) begin
      rv2   = '0;
      busy2 = 1'b0;
    end
  end

  assign bus.rv1   = rv1;
  assign bus.rv2   = rv2;
  assign bus.busy1 = busy1;
  assign bus.busy2 = busy2;

endmodule
